pwm_multi_chan: RTL and testbench
=================================

Name: pwm_multi_chan

Overview:
- Parametrised multi-channel successor to the single-channel PWM generator.
- Drives CHANNELS independent PWM outputs from one shared prescaler and step counter, with configurable duty resolution.
- Per-channel shadow duty registers are committed only at period boundaries, giving glitch-free updates.
- Optional phase staggering spreads channel edges to reduce simultaneous switching current.
- Sits between the satellite register/command decoder and the LED/actuator output pins.

Parameters:
- CHANNELS, 4: number of PWM outputs; range 1-16.
- RES_BITS, 8: duty resolution; one period = 2^RES_BITS steps; range 4-12.
- PRESCALE, 1: step-length multiplier; 1 gives 1.25 kHz at RES_BITS=8, 100 gives 12.5 Hz.
- STEP_BASE, `K1_25_PWM_STEP: masterClk cycles per step at PRESCALE=1; benches override it with a small value.
- STAGGER, 0: 1 = channel i phase offset is i*(2^RES_BITS/CHANNELS) steps (integer divide); 0 = all channels aligned.

Ports:
- masterClk, in, 1: master clock, >30 MHz; all logic on posedge.
- reset, in, 1: asynchronous, active-high; clears all state.
- controlInput, in, RES_BITS: duty value to load.
- chanSel, in, max(1,$clog2(CHANNELS)): target channel for load.
- load, in, 1: controlInput/chanSel sampled on rising edge (internally edge-detected).
- pwmOut, out, CHANNELS: registered PWM outputs.
- pending, out, CHANNELS: shadow written but not yet committed.
- periodStart, out, 1: one-cycle pulse at each period boundary commit.

Behaviour:
- Reset: pwmOut=0, pending=0, periodStart=0. Prescaler, stepCnt, all active/shadow duties and prevLoad = 0.
- Prescaler: counts 0..STEP_BASE*PRESCALE-1. stepTick asserts on the terminal count, and the counter then wraps to 0.
- stepCnt (RES_BITS wide) increments on stepTick and wraps from 2^RES_BITS-1 to 0.
- Boundary = stepTick while stepCnt == 2^RES_BITS-1.
- Load edge: detected when load=1 and prevLoad=0, with prevLoad a flop. On the edge, shadow[chanSel] <= controlInput and pending[chanSel] <= 1.
  - chanSel >= CHANNELS: load is ignored, no state change.
- Commit: on boundary, for every channel with pending=1, active <= shadow and pending <= 0. periodStart pulses in the following cycle.
- Load coinciding with boundary: the commit uses the pre-load shadow value.
  - The new value is written to shadow and pending[chanSel] is left at 1, so it commits at the next boundary.
  - This applies even if that channel was just committed in the same cycle.
- Compare, per channel i: phStep = (stepCnt + offset_i) mod 2^RES_BITS.
  - active == 0: output constant 0.
  - active == 2^RES_BITS-1: output constant 1 (100 %).
  - Otherwise: output 1 while phStep < active.
  - pwmOut is registered, lagging the counter state by one masterClk cycle.
- Duty change never truncates or extends the running period. The new duty takes effect from the first step of the next period.
- Reset mid-period: outputs drop to 0 asynchronously. After release, counting restarts at step 0 with all duties 0 until new loads commit.
- All arithmetic is unsigned. Prescaler width is $clog2(STEP_BASE*PRESCALE), minimum 1 bit.

Decomposition:
- Shared package/include `pwmPkg.v` holds:
  - `K1_25_PWM_STEP` reuse;
  - macros for full-scale duty value ((1<<RES_BITS)-1);
  - the stagger offset formula.
- Natural sub-module: pwm_chan_cmp, one per channel via generate. It contains active/shadow/pending registers, commit logic, phase add and output compare/register.
- Top level keeps the prescaler, step counter, load edge detect and channel decode.

Test Plan (STEP_BASE=2, PRESCALE=1, RES_BITS=4, CHANNELS=4 unless noted):
- Reset released, no loads -> pwmOut=0000, pending=0000 for 3 full periods (96 clk); periodStart pulses every 32 clk.
- Load ch1=8 mid-period -> pending[1]=1 immediately, pwmOut[1] stays 0 until the boundary. From the next period, pwmOut[1] is high 16 clk / low 16 clk, and pending[1] clears at commit.
- Load ch0=0 and ch2=15 -> pwmOut[0] constant 0 and pwmOut[2] constant 1 across multiple boundaries, with no 1-cycle glitch.
- Load pulse aligned with the boundary cycle (ch3 4->12) -> the current boundary commits the old shadow, pending[3] stays 1, and 12 takes effect one period later.
- STAGGER=1, all channels duty 4 -> rising edges of ch0..ch3 are offset by 4 steps (8 clk) each, with an identical 8-clk high width.
- Assert reset mid-period with ch1 at duty 8 -> pwmOut drops to 0 asynchronously. After release, the step counter restarts at 0 and ch1 stays 0 until reloaded. Also, load with chanSel=5 (CHANNELS=4, 3-bit chanSel) -> no change to any shadow or pending.

Source files
------------

// File: rtl/pwm_multi_chan_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel PWM.
package pwm_multi_chan_pkg;

  // masterClk cycles per PWM step at PRESCALE=1 (32 MHz / 320 kHz -> 1.25 kHz at 8 bits).
  localparam int unsigned K1_25_PWM_STEP = 100;

  // Full-scale duty value: (1 << res_bits) - 1, which forces a constant-high output.
  function automatic int unsigned full_scale(input int unsigned res_bits);
    return (32'd1 << res_bits) - 32'd1;
  endfunction

  // Phase offset of a channel in steps; zero when staggering is disabled.
  function automatic int unsigned stagger_offset(input int unsigned chan,
                                                 input int unsigned res_bits,
                                                 input int unsigned channels,
                                                 input int unsigned stagger);
    return (stagger != 0) ? chan * ((32'd1 << res_bits) / channels) : 32'd0;
  endfunction

  // Width of a counter covering 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pwm_multi_chan_cmp.sv
// One PWM channel: shadow/active duty, period-boundary commit and registered compare.
module pwm_chan_cmp
  import pwm_multi_chan_pkg::*;
#(
  parameter int unsigned RES_BITS = 8,
  parameter int unsigned OFFSET   = 0
) (
  input  logic                masterClk,
  input  logic                reset,
  input  logic [RES_BITS-1:0] stepCnt_i,
  input  logic                boundary_i,
  input  logic                wrEn_i,
  input  logic [RES_BITS-1:0] wrData_i,
  output logic                pwm_o,
  output logic                pending_o
);

  localparam logic [RES_BITS-1:0] FULL = RES_BITS'(full_scale(RES_BITS));
  localparam logic [RES_BITS-1:0] OFS  = RES_BITS'(OFFSET);

  logic [RES_BITS-1:0] active_q, active_d;
  logic [RES_BITS-1:0] shadow_q, shadow_d;
  logic                pending_q, pending_d;
  logic                out_q, out_d;
  logic [RES_BITS-1:0] phStep;

  // Next-state: commit uses the pre-load shadow; a coinciding load keeps pending set.
  always_comb begin
    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (boundary_i && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (wrEn_i) begin
      shadow_d  = wrData_i;
      pending_d = 1'b1;
    end
  end

  // Compare: 0 and full scale are constant levels, otherwise high while phase < duty.
  always_comb begin
    phStep = stepCnt_i + OFS;
    if (active_q == '0) begin
      out_d = 1'b0;
    end else if (active_q == FULL) begin
      out_d = 1'b1;
    end else begin
      out_d = (phStep < active_q);
    end
  end

  // Duty and output registers.
  always_ff @(posedge masterClk or posedge reset) begin
    if (reset) begin
      shadow_q  <= '0;
      active_q  <= '0;
      pending_q <= 1'b0;
      out_q     <= 1'b0;
    end else begin
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      out_q     <= out_d;
    end
  end

  assign pwm_o     = out_q;
  assign pending_o = pending_q;

endmodule

// File: rtl/pwm_multi_chan.sv
// Multi-channel PWM: shared prescaler and step counter, load edge detect, per-channel compare.
module pwm_multi_chan
  import pwm_multi_chan_pkg::*;
#(
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned RES_BITS  = 8,
  parameter int unsigned PRESCALE  = 1,
  parameter int unsigned STEP_BASE = K1_25_PWM_STEP,
  parameter int unsigned STAGGER   = 0,
  parameter int unsigned SEL_W     = cnt_width(CHANNELS)
) (
  input  logic                masterClk,
  input  logic                reset,
  input  logic [RES_BITS-1:0] controlInput,
  input  logic [SEL_W-1:0]    chanSel,
  input  logic                load,
  output logic [CHANNELS-1:0] pwmOut,
  output logic [CHANNELS-1:0] pending,
  output logic                periodStart
);

  localparam int unsigned PRE_N = STEP_BASE * PRESCALE;
  localparam int unsigned PRE_W = cnt_width(PRE_N);
  localparam logic [PRE_W-1:0] PRE_TERM = PRE_W'(PRE_N - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [RES_BITS-1:0] stepCnt_q, stepCnt_d;
  logic                prevLoad_q;
  logic                periodStart_q;
  logic                stepTick;
  logic                boundary;
  logic                loadEdge;
  logic                selValid;
  logic [CHANNELS-1:0] wrEn;

  // Prescaler/step counter next state and boundary detection.
  always_comb begin
    stepTick  = (pre_q == PRE_TERM);
    pre_d     = stepTick ? '0 : pre_q + 1'b1;
    stepCnt_d = stepTick ? stepCnt_q + 1'b1 : stepCnt_q;
    boundary  = stepTick && (stepCnt_q == '1);
  end

  // Load rising edge and channel decode; out-of-range selects write nothing.
  always_comb begin
    loadEdge = load && !prevLoad_q;
    selValid = (32'(chanSel) < CHANNELS);
    wrEn     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wrEn[i] = loadEdge && selValid && (chanSel == SEL_W'(i));
    end
  end

  // Shared timebase, load history and period-start pulse.
  always_ff @(posedge masterClk or posedge reset) begin
    if (reset) begin
      pre_q         <= '0;
      stepCnt_q     <= '0;
      prevLoad_q    <= 1'b0;
      periodStart_q <= 1'b0;
    end else begin
      pre_q         <= pre_d;
      stepCnt_q     <= stepCnt_d;
      prevLoad_q    <= load;
      periodStart_q <= boundary;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_chan_cmp #(
      .RES_BITS (RES_BITS),
      .OFFSET   (stagger_offset(g, RES_BITS, CHANNELS, STAGGER))
    ) u_cmp (
      .masterClk  (masterClk),
      .reset      (reset),
      .stepCnt_i  (stepCnt_q),
      .boundary_i (boundary),
      .wrEn_i     (wrEn[g]),
      .wrData_i   (controlInput),
      .pwm_o      (pwmOut[g]),
      .pending_o  (pending[g])
    );
  end

  assign periodStart = periodStart_q;

endmodule

// File: tb/tb_pwm_multi_chan.sv
// Scoreboard bench: stimulus queues cycle-stamped expectations, a monitor checks them.
module tb_pwm_multi_chan;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] ctl   = '0;
  logic [2:0] sel   = '0;
  logic       load  = 1'b0;
  logic [3:0] pwm_a, pend_a, pwm_b, pend_b;
  logic       ps_a, ps_b;

  always #5 clk = ~clk;

  pwm_multi_chan #(.CHANNELS(4), .RES_BITS(4), .PRESCALE(1), .STEP_BASE(2),
                   .STAGGER(0), .SEL_W(3)) dut (
    .masterClk(clk), .reset(reset), .controlInput(ctl), .chanSel(sel), .load(load),
    .pwmOut(pwm_a), .pending(pend_a), .periodStart(ps_a));

  pwm_multi_chan #(.CHANNELS(4), .RES_BITS(4), .PRESCALE(1), .STEP_BASE(2),
                   .STAGGER(1), .SEL_W(3)) dut_stg (
    .masterClk(clk), .reset(reset), .controlInput(ctl), .chanSel(sel), .load(load),
    .pwmOut(pwm_b), .pending(pend_b), .periodStart(ps_b));

  typedef struct {
    string      name;
    int         cyc;
    int         inst;
    logic [3:0] pm, pe, nm, ne;
    logic       sm, se;
  } exp_t;

  exp_t q[$];
  int   cyc    = 0;
  int   base   = 4;
  int   errors = 0;
  int   checks = 0;
  bit   done   = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input string name, input int inst, input int n,
                      input logic [3:0] pm, input logic [3:0] pe,
                      input logic [3:0] nm, input logic [3:0] ne,
                      input logic sm, input logic se);
    exp_t e;
    e.name = name; e.cyc = base + n; e.inst = inst;
    e.pm = pm; e.pe = pe; e.nm = nm; e.ne = ne; e.sm = sm; e.se = se;
    q.push_back(e);
  endtask

  // Return 2 time units after relative edge n.
  task automatic go_rel(input int n);
    while (cyc < base + n) begin
      @(posedge clk);
      #1;
    end
    #1;
  endtask

  task automatic ld(input int n, input logic [2:0] s, input logic [3:0] v);
    go_rel(n);
    sel  = s;
    ctl  = v;
    load = 1'b1;
    go_rel(n + 1);
    load = 1'b0;
  endtask

  initial begin : stimulus
    push("reset_a", 0, -2, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    push("reset_b", 1, -2, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    for (int n = 1; n <= 96; n++)
      push("idle", 0, n, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, ((n % 32) == 0));
    go_rel(0);
    reset = 1'b0;

    push("ld1_pend",   0, 101, 4'b0010, 4'b0000, 4'hF, 4'b0010, 1'b0, 1'b0);
    push("ld1_hold",   0, 127, 4'b0010, 4'b0000, 4'hF, 4'b0010, 1'b0, 1'b0);
    push("ld1_commit", 0, 128, 4'b0010, 4'b0000, 4'hF, 4'b0000, 1'b1, 1'b1);
    push("ld1_hi0",    0, 129, 4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ld1_hi1",    0, 144, 4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ld1_lo0",    0, 145, 4'b0010, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ld1_lo1",    0, 160, 4'b0010, 4'b0000, 4'h0, 4'h0, 1'b1, 1'b1);
    push("ld1_hi2",    0, 161, 4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    ld(100, 3'd1, 4'd8);

    push("ld02_pend",  0, 174, 4'h0, 4'h0, 4'hF, 4'b0101, 1'b0, 1'b0);
    push("ld02_hold",  0, 191, 4'b0101, 4'b0000, 4'hF, 4'b0101, 1'b0, 1'b0);
    push("ld02_cmt",   0, 192, 4'b0101, 4'b0000, 4'hF, 4'b0000, 1'b0, 1'b0);
    for (int n = 193; n <= 260; n++) begin
      push("const_a", 0, n, 4'b0101, 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
      push("const_b", 1, n, 4'b0101, 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
    end
    ld(170, 3'd0, 4'd0);
    ld(173, 3'd2, 4'd15);

    push("ch3_pend",   0, 231, 4'h0, 4'h0, 4'b1000, 4'b1000, 1'b0, 1'b0);
    push("ch3_hold",   0, 255, 4'h0, 4'h0, 4'b1000, 4'b1000, 1'b0, 1'b0);
    push("ch3_bnd",    0, 256, 4'b1000, 4'b0000, 4'hF, 4'b1000, 1'b1, 1'b1);
    push("ch3_d4_hi0", 0, 257, 4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ch3_d4_hi1", 0, 264, 4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ch3_d4_lo",  0, 265, 4'b1000, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ch3_still",  0, 287, 4'b1000, 4'b0000, 4'b1000, 4'b1000, 1'b0, 1'b0);
    push("ch3_cmt12",  0, 288, 4'b1000, 4'b0000, 4'hF, 4'b0000, 1'b0, 1'b0);
    push("ch3_d12_hi0",0, 289, 4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ch3_d12_hi1",0, 312, 4'b1000, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("ch3_d12_lo", 0, 313, 4'b1000, 4'b0000, 4'h0, 4'h0, 1'b0, 1'b0);
    ld(230, 3'd3, 4'd4);
    ld(255, 3'd3, 4'd12);

    push("all4_pend_a", 0, 328, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    push("all4_pend_b", 1, 328, 4'h0, 4'h0, 4'hF, 4'hF, 1'b0, 1'b0);
    push("all4_cmt_a",  0, 352, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    push("all4_cmt_b",  1, 352, 4'h0, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    push("align_hi0",   0, 353, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    push("align_hi1",   0, 360, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 1'b0);
    push("align_lo0",   0, 361, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    push("align_lo1",   0, 368, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch0_a",   1, 353, 4'hF, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch0_b",   1, 360, 4'hF, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch3_a",   1, 361, 4'hF, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch3_b",   1, 368, 4'hF, 4'b1000, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch2_a",   1, 369, 4'hF, 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch2_b",   1, 376, 4'hF, 4'b0100, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch1_a",   1, 377, 4'hF, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_ch1_b",   1, 384, 4'hF, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    push("stg_wrap",    1, 385, 4'hF, 4'b0001, 4'h0, 4'h0, 1'b0, 1'b0);
    ld(320, 3'd0, 4'd4);
    ld(322, 3'd1, 4'd4);
    ld(324, 3'd2, 4'd4);
    ld(326, 3'd3, 4'd4);

    push("pre_rst_pend", 0, 392, 4'h0, 4'h0, 4'hF, 4'b0010, 1'b0, 1'b0);
    push("pre_rst_cmt",  0, 416, 4'h0, 4'h0, 4'hF, 4'b0000, 1'b0, 1'b0);
    push("pre_rst_hi0",  0, 417, 4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    push("pre_rst_hi1",  0, 419, 4'b0010, 4'b0010, 4'h0, 4'h0, 1'b0, 1'b0);
    push("async_rst_a",  0, 420, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    push("async_rst_b",  1, 420, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    push("in_rst_a",     0, 422, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, 1'b0);
    ld(390, 3'd1, 4'd8);
    go_rel(420);
    reset = 1'b1;
    go_rel(424);
    reset = 1'b0;
    base  = base + 424;

    for (int n = 1; n <= 72; n++) begin
      push("post_rst_a", 0, n, 4'hF, 4'h0, 4'hF, 4'h0, 1'b1, ((n == 32) || (n == 64)));
      push("post_rst_b", 1, n, 4'hF, 4'h0, 4'hF, 4'h0, 1'b0, 1'b0);
    end
    ld(6, 3'd5, 4'd9);
    go_rel(80);
    done = 1'b1;
  end

  initial begin : monitor
    logic [3:0] ap, an;
    logic       as;
    while (!(done && (q.size() == 0)) && (cyc < 3000)) begin
      @(negedge clk);
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].cyc == cyc) begin
          ap = (q[k].inst != 0) ? pwm_b  : pwm_a;
          an = (q[k].inst != 0) ? pend_b : pend_a;
          as = (q[k].inst != 0) ? ps_b   : ps_a;
          checks++;
          if (((ap & q[k].pm) !== (q[k].pe & q[k].pm)) ||
              ((an & q[k].nm) !== (q[k].ne & q[k].nm)) ||
              ((as & q[k].sm) !== (q[k].se & q[k].sm))) begin
            errors++;
            $display("FAIL %s cyc=%0d inst=%0d pwm got %b want %b, pending got %b want %b, periodStart got %b want %b",
                     q[k].name, cyc, q[k].inst, ap & q[k].pm, q[k].pe & q[k].pm,
                     an & q[k].nm, q[k].ne & q[k].nm, as & q[k].sm, q[k].se & q[k].sm);
          end
          q.delete(k);
        end
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL timeout cyc=%0d got stimulus unfinished want finished", cyc);
    end
    foreach (q[k]) begin
      checks++;
      errors++;
      $display("FAIL %s cyc=%0d got never sampled want sampled", q[k].name, q[k].cyc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
